// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed 8-tap FIR controller: ring buffer, one shared MAC walked one tap per clock,
// then arithmetic-shift normalisation and saturation into a registered output sample.
module fir_tap_sequencer #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned TAPS     = 8,
  parameter int unsigned ACC_W    = 24
) (
  input  logic                       inClk,
  input  logic                       inReset_n,
  input  logic signed [SAMPLE_W-1:0] inSample,
  input  logic                       inSampleValid,
  input  logic [2:0]                 inFilterType,
  output logic                       outBusy,
  output logic signed [SAMPLE_W-1:0] outSample,
  output logic                       outSampleValid,
  output logic                       outOverrun
);

  localparam int unsigned PTR_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PROD_W = 2 * SAMPLE_W;
  localparam int unsigned SH_W   = 5;

  localparam logic [2:0] TYPE_AVG = 3'b000;
  localparam logic [2:0] TYPE_LP  = 3'b001;
  localparam logic [2:0] TYPE_HP  = 3'b010;
  localparam logic [2:0] TYPE_BYP = 3'b101;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (SAMPLE_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_NORM = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            tap_q, tap_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [2:0]                  type_q, type_d;
  logic signed [SAMPLE_W-1:0]  ring_q [TAPS];
  logic signed [SAMPLE_W-1:0]  ring_d [TAPS];
  logic signed [SAMPLE_W-1:0]  out_sample_q, out_sample_d;
  logic                        out_valid_q, out_valid_d;
  logic                        overrun_q, overrun_d;
  logic                        busy_q, busy_d;

  logic [PTR_W-1:0]            rd_idx_c;
  logic signed [SAMPLE_W-1:0]  coef_c;
  logic signed [PROD_W-1:0]    prod_c;
  logic [SH_W-1:0]             shift_c;
  logic signed [ACC_W-1:0]     shifted_c;
  logic signed [SAMPLE_W-1:0]  sat_c;

  // Binomial kernel magnitudes; highpass flips the sign of the even taps.
  function automatic logic signed [SAMPLE_W-1:0] coef_f(input logic [2:0] ftype,
                                                        input logic [PTR_W-1:0] tap);
    int idx;
    int mag;
    idx = int'(tap);
    case (idx)
      0, 7:    mag = 1;
      1, 6:    mag = 7;
      2, 5:    mag = 21;
      3, 4:    mag = 35;
      default: mag = 0;
    endcase
    case (ftype)
      TYPE_AVG: coef_f = SAMPLE_W'(1);
      TYPE_LP:  coef_f = SAMPLE_W'(mag);
      TYPE_HP:  coef_f = idx[0] ? SAMPLE_W'(mag) : SAMPLE_W'(-mag);
      TYPE_BYP: coef_f = (idx == 0) ? SAMPLE_W'(1) : SAMPLE_W'(0);
      default:  coef_f = SAMPLE_W'(0);
    endcase
  endfunction

  // Tap 0 reads the newest sample, which sits one slot behind the write pointer.
  assign rd_idx_c = wr_ptr_q - PTR_W'(1) - tap_q;
  assign coef_c   = coef_f(type_q, tap_q);
  assign prod_c   = PROD_W'(ring_q[rd_idx_c]) * PROD_W'(coef_c);

  always_comb begin
    case (type_q)
      TYPE_AVG:        shift_c = SH_W'(PTR_W);
      TYPE_LP, TYPE_HP: shift_c = SH_W'(7);
      default:         shift_c = SH_W'(0);
    endcase
  end

  assign shifted_c = acc_q >>> shift_c;

  always_comb begin
    if (shifted_c > SAT_MAX) begin
      sat_c = SAMPLE_W'(SAT_MAX);
    end else if (shifted_c < SAT_MIN) begin
      sat_c = SAMPLE_W'(SAT_MIN);
    end else begin
      sat_c = SAMPLE_W'(shifted_c);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    type_d       = type_q;
    ring_d       = ring_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (inSampleValid) begin
          ring_d[wr_ptr_q] = inSample;
          wr_ptr_d         = wr_ptr_q + PTR_W'(1);
          type_d           = inFilterType;
          acc_d            = '0;
          tap_d            = '0;
          state_d          = S_MAC;
        end
      end
      S_MAC: begin
        overrun_d = inSampleValid;
        acc_d     = acc_q + ACC_W'(prod_c);
        if (tap_q == PTR_W'(TAPS - 1)) begin
          state_d = S_NORM;
        end else begin
          tap_d = tap_q + PTR_W'(1);
        end
      end
      S_NORM: begin
        overrun_d    = inSampleValid;
        out_sample_d = sat_c;
        out_valid_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge inClk or negedge inReset_n) begin
    if (!inReset_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      type_q       <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      type_q       <= type_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      for (int i = 0; i < int'(TAPS); i++) begin
        ring_q[i] <= ring_d[i];
      end
    end
  end

  assign outBusy        = busy_q;
  assign outSample      = out_sample_q;
  assign outSampleValid = out_valid_q;
  assign outOverrun     = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer against a history-array FIR model.
module tb_fir_tap_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [11:0] in_sample;
  logic              in_valid;
  logic [2:0]        in_type;
  logic              busy;
  logic signed [11:0] out_sample;
  logic              out_valid;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  int hist [8];
  int lp_k [8] = '{1, 7, 21, 35, 35, 21, 7, 1};
  int hp_k [8] = '{-1, 7, -21, 35, -35, 21, -7, 1};

  fir_tap_sequencer dut (
    .inClk         (clk),
    .inReset_n     (rst_n),
    .inSample      (in_sample),
    .inSampleValid (in_valid),
    .inFilterType  (in_type),
    .outBusy       (busy),
    .outSample     (out_sample),
    .outSampleValid(out_valid),
    .outOverrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) hist[i] = 0;
  endfunction

  // hist[0] is the newest accepted sample; returns the expected filter output.
  function automatic int model_push(input int s, input int t);
    int sum;
    int r;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    if (t == 5) return hist[0];
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      case (t)
        0:       sum += hist[i];
        1:       sum += lp_k[i] * hist[i];
        2:       sum += hp_k[i] * hist[i];
        default: sum += 0;
      endcase
    end
    case (t)
      0:       r = sum >>> 3;
      1, 2:    r = sum >>> 7;
      default: r = 0;
    endcase
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return r;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One accepted sample; reports the result, latency in clocks and the valid level one clock later.
  task automatic run_sample(input int s, input int t, output int val, output int lat,
                            output logic after);
    @(negedge clk);
    in_sample = 12'(s);
    in_type   = 3'(t);
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat   = -1;
    val   = 0;
    after = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        val = int'(out_sample);
        break;
      end
    end
    @(posedge clk);
    #1 after = out_valid;
  endtask

  task automatic test_reset();
    in_sample = '0;
    in_type   = '0;
    do_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (out_sample !== 12'sd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", out_sample); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_bypass_latency();
    int val, lat, exp;
    logic after;
    exp = model_push(100, 5);
    run_sample(100, 5, val, lat, after);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL bypass_latency: got %0d expected 9", lat); end
    checks++;
    if (val !== exp) begin errors++; $display("FAIL bypass_value: got %0d expected %0d", val, exp); end
    checks++;
    if (after !== 1'b0) begin errors++; $display("FAIL bypass_pulse_width: valid %b one clock later, expected 0", after); end
  endtask

  task automatic test_reset_mid_mac();
    logic seen;
    @(negedge clk);
    in_sample = 12'sd321;
    in_type   = 3'd1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_mac_busy_before: got %b expected 1", busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_mac_reset_busy: got %b expected 0", busy); end
    checks++;
    if (out_sample !== 12'sd0) begin errors++; $display("FAIL mid_mac_reset_sample: got %0d expected 0", out_sample); end
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL mid_mac_reset_pulses: valid %b overrun %b expected 0 0", out_valid, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_mac_no_valid: got %b expected 0", seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_mac_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_avg();
    int val, lat, exp;
    logic after;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      exp = model_push(800, 0);
      run_sample(800, 0, val, lat, after);
      checks++;
      if (val !== 100 * (k + 1) || lat !== 9) begin
        errors++; $display("FAIL avg_step%0d: got %0d lat %0d expected %0d lat 9", k, val, lat, 100 * (k + 1));
      end
    end
    do_reset();
    exp = model_push(-1, 0);
    run_sample(-1, 0, val, lat, after);
    checks++;
    if (val !== -1) begin errors++; $display("FAIL avg_floor_shift: got %0d expected -1", val); end
  endtask

  task automatic test_lowpass_highpass();
    int val, lat, exp, s;
    logic after;
    for (int t = 1; t <= 2; t++) begin
      do_reset();
      for (int k = 0; k < 8; k++) begin
        s   = (k == 0) ? 128 : 0;
        exp = model_push(s, t);
        run_sample(s, t, val, lat, after);
        checks++;
        if (val !== ((t == 1) ? lp_k[k] : hp_k[k])) begin
          errors++;
          $display("FAIL impulse_type%0d_tap%0d: got %0d expected %0d", t, k, val, (t == 1) ? lp_k[k] : hp_k[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int val, lat, exp, s;
    logic after;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      s   = (k % 2 == 0) ? -2048 : 2047;
      exp = model_push(s, 2);
      run_sample(s, 2, val, lat, after);
      checks++;
      if (val !== exp) begin errors++; $display("FAIL sat_step%0d: got %0d expected %0d", k, val, exp); end
      if (k >= 7) begin
        checks++;
        if (val !== 2047 && val !== -2048) begin
          errors++; $display("FAIL sat_rail%0d: got %0d expected a rail value", k, val);
        end
      end
    end
  endtask

  task automatic test_overrun_type_change();
    int val, lat, exp, ovr;
    logic after;
    do_reset();
    exp = model_push(500, 1);
    @(negedge clk);
    in_sample = 12'sd500;
    in_type   = 3'd1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    ovr = 0;
    lat = -1;
    val = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        @(negedge clk);
        in_valid  = 1'b1;
        in_type   = 3'd5;
        in_sample = 12'sd999;
      end
      @(posedge clk);
      #1;
      if (k == 3) begin
        in_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b expected 1", overrun); end
      end
      if (overrun) ovr++;
      if (out_valid) begin
        lat = k;
        val = int'(out_sample);
        break;
      end
    end
    checks++;
    if (ovr !== 1) begin errors++; $display("FAIL overrun_count: got %0d expected 1", ovr); end
    checks++;
    if (lat !== 9 || val !== exp) begin
      errors++; $display("FAIL overrun_orig_type: got %0d lat %0d expected %0d lat 9", val, lat, exp);
    end
    exp = model_push(77, 5);
    run_sample(77, 5, val, lat, after);
    checks++;
    if (val !== exp) begin errors++; $display("FAIL overrun_next_bypass: got %0d expected %0d", val, exp); end
    exp = model_push(0, 1);
    run_sample(0, 1, val, lat, after);
    checks++;
    if (val !== exp) begin errors++; $display("FAIL overrun_buffer_untouched: got %0d expected %0d", val, exp); end
  endtask

  task automatic test_back_to_back();
    int val, lat, exp, ovr, s;
    do_reset();
    s = int'($urandom_range(4095)) - 2048;
    exp = model_push(s, 0);
    @(negedge clk);
    in_sample = 12'(s);
    in_type   = 3'd0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      ovr = 0;
      lat = -1;
      val = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (overrun) ovr++;
        if (out_valid) begin
          lat = k;
          val = int'(out_sample);
          break;
        end
      end
      checks++;
      if (lat !== 9 || val !== exp || ovr !== 9) begin
        errors++;
        $display("FAIL held_valid%0d: got %0d lat %0d overruns %0d expected %0d lat 9 overruns 9", r, val, lat, ovr, exp);
      end
      s = int'($urandom_range(4095)) - 2048;
      in_sample = 12'(s);
      exp = model_push(s, 0);
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || overrun !== 1'b0) begin
        errors++; $display("FAIL held_reaccept%0d: busy %b overrun %b expected 1 0", r, busy, overrun);
      end
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int val, lat, exp, s, t;
    logic after;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      s   = int'($urandom_range(4095)) - 2048;
      t   = int'($urandom_range(7));
      exp = model_push(s, t);
      run_sample(s, t, val, lat, after);
      checks++;
      if (val !== exp || lat !== 9 || after !== 1'b0) begin
        errors++;
        $display("FAIL random%0d type %0d: got %0d lat %0d after %b expected %0d lat 9 after 0", n, t, val, lat, after, exp);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    in_type   = '0;
    model_clear();
    test_reset();
    test_bypass_latency();
    test_reset_mid_mac();
    test_avg();
    test_lowpass_highpass();
    test_saturation();
    test_overrun_type_change();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
